alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command-driven initiator for the 16-bit structural ALU (AND/NOT/ADD/SAT). It sits on the other end of the ALU's a/b/s/out interface.
- Accepts operation commands from a host over a valid/ready handshake and drives the ALU operands and select.
- Waits a fixed settle time for the gate-level ALU, captures the result into an accumulator, and returns the result plus flags over a second valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width; matches ALU a/b/out.
- SETTLE, 3, cycles alu_out is allowed to settle before capture; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  ALU select: 00 AND, 01 NOT, 10 ADD, 11 SAT.
- cmd_load  input  1  1 = load cmd_data into acc without using the ALU.
- cmd_data  input  WIDTH  operand b, or the load value.
- alu_a  output  WIDTH  to ALU a; always equals acc.
- alu_b  output  WIDTH  to ALU b.
- alu_s  output  2  to ALU s.
- alu_out  input  WIDTH  from ALU out.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  host accepts result.
- rsp_data  output  WIDTH  captured result (new acc).
- rsp_zero  output  1  rsp_data == 0.
- rsp_ovf  output  1  signed overflow; ADD only.
- acc  output  WIDTH  accumulator value.

Behaviour:
- Reset (async, immediate): state IDLE; acc=0; alu_b=0; alu_s=00; settle counter=0; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_zero=0; rsp_ovf=0.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - cmd_valid & cmd_load: acc<=cmd_data; rsp_data<=cmd_data; rsp_zero<=(cmd_data==0); rsp_ovf<=0; go to RESP. The ALU is not used.
  - cmd_valid & !cmd_load: alu_b<=cmd_data; alu_s<=cmd_op; counter<=SETTLE-1; go to SETTLE.
- SETTLE:
  - cmd_ready=0.
  - alu_a/alu_b/alu_s are held stable for exactly SETTLE cycles.
  - While counter!=0, decrement.
  - When counter==0:
    - acc<=alu_out; rsp_data<=alu_out; rsp_zero<=(alu_out==0).
    - rsp_ovf<=(alu_s==10) & (acc[15]==alu_b[15]) & (alu_out[15]!=acc[15]).
    - Go to RESP.
- RESP:
  - rsp_valid=1; cmd_ready=0.
  - rsp_data, rsp_zero and rsp_ovf are held stable until rsp_ready=1 is sampled; then go to IDLE.
  - rsp_valid drops the cycle after the handshake.
  - The next command can be accepted no earlier than that cycle: no overlap between responses and commands.
- Latency, cmd handshake to rsp_valid rising:
  - load: 1 cycle.
  - ALU op: SETTLE+1 cycles.
- The block never interprets op semantics except for the ADD overflow flag; SAT results, including per-lane behaviour, come from the ALU unmodified.
- cmd_data and cmd_op are sampled only on the accept cycle; later changes are ignored.
- rsp_ready asserted outside RESP is ignored.
- alu_s/alu_b keep their last values in IDLE and RESP; they are not cleared.
- Reset asserted mid-SETTLE or mid-RESP: the command is dropped, acc is cleared, no response is issued, and all outputs take reset values immediately.

Test Plan:
- Reset then load: cmd_load=1, cmd_data=0x1234 -> rsp_valid next cycle, rsp_data=0x1234, acc=0x1234, rsp_zero=0, rsp_ovf=0.
- ADD overflow:
  - Stimulus: acc=0x7FFF, op=10, data=0x0001, ALU model returns 0x8000.
  - Response: alu_s=10 and alu_b=0x0001 held for SETTLE=3 cycles; rsp_valid 4 cycles after accept; rsp_data=0x8000, rsp_ovf=1.
- AND to zero: acc=0x00FF, op=00, data=0xFF00, ALU returns 0x0000 -> rsp_zero=1, rsp_ovf=0, acc=0.
- Response backpressure:
  - Stimulus: rsp_ready held 0 for 5 cycles after rsp_valid, while cmd_valid is held 1.
  - Response: rsp_data stable throughout; cmd_ready=0 until the cycle after the rsp handshake; then the pending command is accepted.
- Operand stability: change cmd_data and cmd_op every cycle during SETTLE -> alu_b and alu_s unchanged; captured result corresponds to the accepted values.
- Reset mid-SETTLE: assert rst at the 2nd SETTLE cycle -> acc=0, rsp_valid never rises, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 16-bit structural ALU: accepts host commands, drives the ALU
// operands, waits a fixed settle time, captures the result and returns it with flags.
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    localparam logic [1:0] OpAdd = 2'b10;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_s_q, alu_s_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= 2'b00;
            cnt_q      <= 4'd0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            alu_b_q    <= alu_b_d;
            alu_s_q    <= alu_s_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        alu_b_d    = alu_b_q;
        alu_s_d    = alu_s_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_ovf_d  = rsp_ovf_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d      = cmd_data;
                        rsp_data_d = cmd_data;
                        rsp_zero_d = (cmd_data == '0);
                        rsp_ovf_d  = 1'b0;
                        state_d    = StResp;
                    end else begin
                        alu_b_d = cmd_data;
                        alu_s_d = cmd_op;
                        cnt_d   = 4'(SETTLE - 1);
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    acc_d      = alu_out;
                    rsp_data_d = alu_out;
                    rsp_zero_d = (alu_out == '0);
                    // Signed overflow: operands agree in sign, result disagrees with acc.
                    rsp_ovf_d  = (alu_s_q == OpAdd)
                               & (acc_q[WIDTH-1] == alu_b_q[WIDTH-1])
                               & (alu_out[WIDTH-1] != acc_q[WIDTH-1]);
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign alu_a     = acc_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign acc       = acc_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model on the a/b/s/out side.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_load;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_s;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_ovf;
    logic [15:0] rsp_data, acc;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(16), .SETTLE(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_load (cmd_load),
        .cmd_data (cmd_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_out  (alu_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_zero (rsp_zero),
        .rsp_ovf  (rsp_ovf),
        .acc      (acc)
    );

    // ALU model: AND, NOT a, ADD (wrapping), SAT (unsigned saturating add)
    logic [16:0] sum17;
    always_comb begin
        sum17 = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_s)
            2'b00:   alu_out = alu_a & alu_b;
            2'b01:   alu_out = ~alu_a;
            2'b10:   alu_out = sum17[15:0];
            default: alu_out = sum17[16] ? 16'hFFFF : sum17[15:0];
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        load;
        logic [1:0]  op;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic        exp_zero;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    // Issue one command, wait for its response, acknowledge it; returns what was observed.
    task automatic run_cmd(input logic load, input logic [1:0] op, input logic [15:0] data,
                           output logic [15:0] d, output logic z, output logic o,
                           output int lat);
        int wait_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = load;
        cmd_op    = op;
        cmd_data  = data;
        wait_cnt  = 0;
        while (!cmd_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        d = rsp_data;
        z = rsp_zero;
        o = rsp_ovf;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
    endtask

    vec_t        vecs[$];
    logic [15:0] d;
    logic        z, o;
    int          lat;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 2'b00;
        cmd_data = 16'h0; rsp_ready = 1'b0;

        // load/op, data, result, zero, ovf, latency
        vecs.push_back('{1'b1, 2'b00, 16'h1234, 16'h1234, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 2'b00, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b10, 16'h0001, 16'h8000, 1'b0, 1'b1, 4});
        vecs.push_back('{1'b1, 2'b00, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b00, 16'hFF00, 16'h0000, 1'b1, 1'b0, 4});
        vecs.push_back('{1'b0, 2'b01, 16'h5555, 16'hFFFF, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b0, 2'b10, 16'h0001, 16'h0000, 1'b1, 1'b0, 4});
        vecs.push_back('{1'b1, 2'b00, 16'h8000, 16'h8000, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b10, 16'h8000, 16'h0000, 1'b1, 1'b1, 4});
        vecs.push_back('{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 2'b00, 16'h7000, 16'h7000, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 2'b11, 16'h7000, 16'hE000, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b0, 2'b11, 16'h3000, 16'hFFFF, 1'b0, 1'b0, 4});

        #12;
        chk("reset_cmd_ready", 32'(cmd_ready), 1);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_acc", 32'(acc), 0);
        chk("reset_alu_b", 32'(alu_b), 0);
        chk("reset_alu_s", 32'(alu_s), 0);
        chk("reset_rsp_data", 32'({rsp_data, rsp_zero, rsp_ovf}), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_cmd(vecs[i].load, vecs[i].op, vecs[i].data, d, z, o, lat);
            chk($sformatf("v%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_zero", i), 32'(z), 32'(vecs[i].exp_zero));
            chk($sformatf("v%0d_ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_acc", i), 32'(acc), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_alu_a", i), 32'(alu_a), 32'(vecs[i].exp_data));
        end
        chk("alu_s_kept_idle", 32'(alu_s), 32'(2'b11));
        chk("alu_b_kept_idle", 32'(alu_b), 32'(16'h3000));

        // Backpressure with a pending command held on the cmd side
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 16'h0042;
        @(negedge clk);
        cmd_data = 16'h0099;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("bp%0d_rsp_data", i), 32'(rsp_data), 32'(16'h0042));
            chk($sformatf("bp%0d_cmd_ready", i), 32'(cmd_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_after_hs_rsp_valid", 32'(rsp_valid), 0);
        chk("bp_after_hs_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_pending_rsp_valid", 32'(rsp_valid), 1);
        chk("bp_pending_rsp_data", 32'(rsp_data), 32'(16'h0099));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Operand stability while inputs churn during SETTLE
        run_cmd(1'b1, 2'b00, 16'h0F0F, d, z, o, lat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b10; cmd_data = 16'h0101;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cmd_data = 16'(16'hA5A5 + i);
            cmd_op   = 2'(i);
            cmd_valid = 1'b0;
            chk($sformatf("st%0d_alu_b", i), 32'(alu_b), 32'(16'h0101));
            chk($sformatf("st%0d_alu_s", i), 32'(alu_s), 32'(2'b10));
            chk($sformatf("st%0d_cmd_ready", i), 32'(cmd_ready), 0);
            @(negedge clk);
        end
        chk("st_rsp_valid", 32'(rsp_valid), 1);
        chk("st_rsp_data", 32'(rsp_data), 32'(16'h1010));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during the second SETTLE cycle
        run_cmd(1'b1, 2'b00, 16'h5555, d, z, o, lat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b10; cmd_data = 16'h0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_acc", 32'(acc), 0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_mid_alu_b", 32'(alu_b), 0);
        chk("rst_mid_alu_s", 32'(alu_s), 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            chk("rst_mid_no_rsp", 32'(seen), 0);
        end
        chk("rst_mid_cmd_ready_after", 32'(cmd_ready), 1);
        chk("rst_mid_acc_after", 32'(acc), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
